// File: rtl/ifetch_unit.sv
// ifetch_unit -- instruction fetch front end.
//
// Owns the PC, issues in-order word fetches to instruction memory, buffers the
// returned words together with their PC and hands them to decode. A redirect
// from execute replaces the PC, empties the buffer and discards every response
// still in flight for the old path.
//
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   o_imem_req_valid/_addr    fetch request (word aligned address)
//   i_imem_req_ready          memory accepts the request
//   i_imem_rsp_valid/_data    response word, returned in request order
//   i_redirect, i_redirect_pc taken branch/jump and its target
//   o_inst_valid, i_inst_ready decode handshake
//   o_inst, o_inst_pc, o_inst_pcplus4  buffer head word, its PC and PC + 4
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  output logic        o_imem_req_valid,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_req_ready,
  input  logic        i_imem_rsp_valid,
  input  logic [31:0] i_imem_rsp_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic [31:0] o_inst_pcplus4
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_out_cnt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_drop_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_buf_inst [DEPTH];
  logic [31:0]   r_buf_pc   [DEPTH];

  logic          w_pop;
  logic [CW:0]   w_credit;
  logic          w_req_acc;
  logic          w_redir;
  logic [31:0]   w_target;
  logic [CW-1:0] w_out_next;
  logic          w_dropping;
  logic          w_push;

  assign w_pop    = o_inst_valid & i_inst_ready;
  // Outstanding plus buffered words, counting the slot freed by this cycle's pop,
  // may never exceed DEPTH: every response then has a guaranteed buffer slot.
  assign w_credit = {1'b0, r_out_cnt} + {1'b0, r_cnt} - {{CW{1'b0}}, w_pop};

  assign o_imem_req_valid = (r_state == ST_RUN) && (w_credit < (CW+1)'(DEPTH));
  assign o_imem_req_addr  = r_fetch_pc;
  assign w_req_acc        = o_imem_req_valid & i_imem_req_ready;

  assign w_redir    = i_redirect & (r_state != ST_BOOT);
  assign w_target   = i_redirect_pc & 32'hFFFF_FFFC;
  // Requests still owed a response after this edge; on a redirect all of them
  // belong to the old path and become the drop count.
  assign w_out_next = r_out_cnt + CW'(w_req_acc) - CW'(i_imem_rsp_valid);
  assign w_dropping = (r_drop_cnt != '0);
  assign w_push     = i_imem_rsp_valid & ~w_redir & ~w_dropping;

  assign o_inst_valid   = (r_cnt != '0);
  // Head outputs read as zero while empty so reset clears them immediately.
  assign o_inst         = o_inst_valid ? r_buf_inst[r_rd_ptr] : 32'h0;
  assign o_inst_pc      = o_inst_valid ? r_buf_pc[r_rd_ptr] : 32'h0;
  assign o_inst_pcplus4 = o_inst_valid ? (r_buf_pc[r_rd_ptr] + 32'd4) : 32'h0;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_BOOT;
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_out_cnt  <= '0;
      r_cnt      <= '0;
      r_drop_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      r_out_cnt <= w_out_next;

      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        default: begin
          if (w_redir) begin
            r_state <= (w_out_next != '0) ? ST_FLUSH : ST_RUN;
          end else if (r_state == ST_FLUSH && i_imem_rsp_valid && r_drop_cnt == CW'(1)) begin
            r_state <= ST_RUN;
          end
        end
      endcase

      if (w_redir) begin
        r_fetch_pc <= w_target;
        r_rsp_pc   <= w_target;
        r_drop_cnt <= w_out_next;
        r_cnt      <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_req_acc) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (i_imem_rsp_valid && w_dropping) begin
          r_drop_cnt <= r_drop_cnt - CW'(1);
        end
        if (w_push) begin
          r_rsp_pc <= r_rsp_pc + 32'd4;
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Buffer storage carries no reset; only entries below r_cnt are ever read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_buf_inst[r_wr_ptr] <= i_imem_rsp_data;
      r_buf_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

  // A response with the buffer full means the memory returned more words than
  // were requested.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    i_imem_rsp_valid |-> (r_cnt != CW'(DEPTH)));

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit -- directed bench for ifetch_unit.
//
// A small in-order memory model answers every accepted request after a chosen
// latency with addr ^ 32'hA5A5_0000. Inputs change just after the falling edge,
// outputs are sampled 1 ns later, and delivered PCs are collected in order.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] inst_pcplus4;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] got[$];
  int          cyc;
  int          lat;
  int          acc_cnt;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  ifetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .i_clk            (clk),
    .i_reset_n        (reset_n),
    .o_imem_req_valid (req_valid),
    .o_imem_req_addr  (req_addr),
    .i_imem_req_ready (req_ready),
    .i_imem_rsp_valid (rsp_valid),
    .i_imem_rsp_data  (rsp_data),
    .i_redirect       (redirect),
    .i_redirect_pc    (redirect_pc),
    .o_inst_valid     (inst_valid),
    .i_inst_ready     (inst_ready),
    .o_inst           (inst),
    .o_inst_pc        (inst_pc),
    .o_inst_pcplus4   (inst_pcplus4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end else begin
      $display("  vec %0d %s: %h ok", n_vec, tag, act);
    end
  endtask

  // Drive the memory response for the current cycle, then let logic settle.
  task automatic settle();
    if (pend.size() > 0 && pend[0].due == cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = pend[0].addr ^ 32'hA5A5_0000;
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = 32'h0;
    end
    #1;
  endtask

  // Record what the coming rising edge will commit, then move to the next cycle.
  task automatic advance();
    if (req_valid && req_ready) begin
      pend.push_back('{req_addr, cyc + lat});
      acc_cnt++;
    end
    if (rsp_valid) pend.delete(0);
    if (inst_valid && inst_ready) begin
      got.push_back(inst_pc);
      check("deliv_word", inst, inst_pc ^ 32'hA5A5_0000);
      check("deliv_pcplus4", inst_pcplus4, inst_pc + 32'd4);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      settle();
      advance();
    end
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_req_valid"}, req_valid, 1'b0);
    check({tag, "_req_addr"}, req_addr, 32'h0);
    check({tag, "_inst_valid"}, inst_valid, 1'b0);
    check({tag, "_inst"}, inst, 32'h0);
    check({tag, "_inst_pc"}, inst_pc, 32'h0);
    check({tag, "_pcplus4"}, inst_pcplus4, 32'h0);
  endtask

  // Hold reset over one falling edge, check reset outputs, release on the next.
  task automatic do_reset();
    reset_n     = 1'b0;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = 32'h0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    inst_ready  = 1'b0;
    pend.delete();
    got.delete();
    acc_cnt = 0;
    @(negedge clk);
    #1;
    check_rst("rst");
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 1;
  endtask

  // Run until decode takes an instruction (bounded) and check its PC.
  task automatic expect_next(input string tag, input logic [31:0] exp);
    int n = 0;
    while (got.size() == 0 && n < 30) begin
      settle();
      advance();
      n++;
    end
    check({tag, "_seen"}, 32'(got.size() > 0), 32'd1);
    if (got.size() > 0) check(tag, got[0], exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Startup latency and back-to-back delivery with a 1-cycle memory.
    do_reset();
    lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
    settle(); check("c1_req_valid", req_valid, 1'b0); advance();
    settle(); check("c2_req_valid", req_valid, 1'b1);
    check("c2_req_addr", req_addr, 32'h0); advance();
    settle(); check("c3_inst_valid", inst_valid, 1'b0); advance();
    settle(); check("c4_inst_valid", inst_valid, 1'b1);
    check("c4_inst_pc", inst_pc, 32'h0);
    check("c4_pcplus4", inst_pcplus4, 32'h4); advance();
    for (int k = 1; k <= 3; k++) begin
      settle();
      check("stream_valid", inst_valid, 1'b1);
      check("stream_pc", inst_pc, 32'(4 * k));
      advance();
    end

    // Decode stall: the credit limit allows exactly two requests.
    do_reset();
    lat = 1; req_ready = 1'b1; inst_ready = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      settle();
      if (c >= 4) check("stall_inst_pc", inst_pc, 32'h0);
      if (c == 10) begin
        check("stall_req_valid", req_valid, 1'b0);
        check("stall_inst", inst, 32'hA5A5_0000);
      end
      advance();
    end
    check("stall_req_count", 32'(acc_cnt), 32'd2);
    inst_ready = 1'b1;
    run(8);
    check("release_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++) check("release_pc", got[i], 32'(4 * i));

    // 3-cycle memory, redirect with two requests outstanding.
    do_reset();
    lat = 3; req_ready = 1'b1; inst_ready = 1'b1;
    run(3);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    settle(); check("flush_c4_req_valid", req_valid, 1'b0); advance();
    redirect = 1'b0;
    for (int c = 5; c <= 6; c++) begin
      settle();
      check("flush_req_valid", req_valid, 1'b0);
      check("flush_inst_valid", inst_valid, 1'b0);
      advance();
    end
    settle(); check("refetch_req_valid", req_valid, 1'b1);
    check("refetch_req_addr", req_addr, 32'h0000_0100); advance();
    expect_next("flush_next_pc", 32'h0000_0100);

    // Redirect coinciding with a response and a pop of PC 8.
    do_reset();
    lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
    run(5);
    redirect = 1'b1; redirect_pc = 32'h0000_0300;
    settle(); check("rr_inst_pc", inst_pc, 32'h8);
    check("rr_rsp_valid_seen", 32'(rsp_valid), 32'd1); advance();
    redirect = 1'b0;
    check("rr_deliv_count", 32'(got.size()), 32'd3);
    if (got.size() == 3) check("rr_last_pc", got[2], 32'h8);
    got.delete();
    settle(); check("rr_inst_valid", inst_valid, 1'b0);
    check("rr_req_valid", req_valid, 1'b0); advance();
    expect_next("rr_next_pc", 32'h0000_0300);

    // Misaligned redirect target is word aligned.
    redirect = 1'b1; redirect_pc = 32'h0000_0206;
    settle(); advance();
    redirect = 1'b0;
    got.delete();
    begin
      int n = 0;
      settle();
      while (!req_valid && n < 10) begin
        advance();
        settle();
        n++;
      end
    end
    check("misalign_req_valid", req_valid, 1'b1);
    check("misalign_req_addr", req_addr, 32'h0000_0204);
    advance();
    expect_next("misalign_pc", 32'h0000_0204);

    // Asynchronous reset mid-stream with one request outstanding.
    run(3);
    settle();
    check("pre_rst_inst_valid", inst_valid, 1'b1);
    reset_n = 1'b0;
    rsp_valid = 1'b0;
    #1;
    check_rst("async");
    pend.delete();
    got.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 1;
    settle(); check("re_c1_req_valid", req_valid, 1'b0); advance();
    settle(); check("re_c2_req_valid", req_valid, 1'b1);
    check("re_c2_req_addr", req_addr, 32'h0); advance();
    expect_next("restart_pc", 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch front end. Produces the instruction stream that the control decoder and datapath consume.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready request channel.
- Buffers returned words with their PC and hands them to decode through a valid/ready handshake.
- Takes branch/jump redirects from execute and flushes in-flight work on each redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction buffer entries; also the cap on outstanding plus buffered instructions (power of 2, at least 2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  32  fetch address, word aligned
- imem_req_ready  in  1  memory accepts request
- imem_rsp_valid  in  1  response word valid, in request order
- imem_rsp_data  in  32  instruction word
- redirect  in  1  taken branch/jump (PCSrc)
- redirect_pc  in  32  target address (PCTarget)
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  32  instruction word; op field is bits [6:0]
- inst_pc  out  32  PC of inst
- inst_pcplus4  out  32  inst_pc + 4

Behaviour:
- Clocking and reset: one clock, clk; reset_n is asynchronous and active-low.
- While reset_n is low:
  - state = BOOT; fetch_pc = RESET_PC
  - imem_req_valid = 0; imem_req_addr = RESET_PC
  - inst_valid = 0; inst, inst_pc, inst_pcplus4 = 0
  - buffer count, outstanding count and drop count = 0
- States: BOOT, RUN, FLUSH.
  - BOOT: one idle cycle after reset release, then RUN unconditionally.
  - RUN: normal fetch.
  - FLUSH: entered on redirect when drop_cnt would be nonzero; returns to RUN in the cycle drop_cnt reaches 0.
- Request issue (RUN only):
  - imem_req_valid = 1 when outstanding + count - pop < DEPTH.
  - pop = inst_valid & inst_ready.
  - imem_req_addr = fetch_pc.
  - A request is accepted on valid & ready: fetch_pc += 4, outstanding += 1.
  - An unaccepted request keeps its address stable unless a redirect occurs.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt > 0, the word is discarded and drop_cnt -= 1.
  - Otherwise the word is written to the buffer with its PC.
  - The PC comes from an internal rsp_pc register that advances by 4 per kept response.
  - The buffer never overflows, by the credit rule. A response arriving with the buffer full is a protocol error; flag it with a simulation-only assertion.
- Decode side:
  - inst_valid = buffer non-empty.
  - inst, inst_pc and inst_pcplus4 come from the buffer head.
  - Values stay stable while inst_valid & !inst_ready.
- Redirect (highest priority, any state except BOOT):
  - Buffer emptied next cycle; inst_valid = 0 next cycle.
  - fetch_pc and rsp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = outstanding + (request accepted this cycle) - (response arriving this cycle).
  - An unaccepted request is withdrawn. No request is issued in the redirect cycle's successor unless drop_cnt = 0, in which case the request goes to the new PC.
- Simultaneous events:
  - Redirect with a response in the same cycle: the response is discarded.
  - Redirect with a pop in the same cycle: the pop completes (decode got the word), then the flush happens.
  - Redirect with a request accepted in the same cycle: that request is counted in drop_cnt.
  - Redirect during FLUSH: drop_cnt is recomputed per the rule above; the newest target wins.
- Latency and throughput:
  - First imem_req_valid in the 2nd cycle after reset release.
  - With a zero-wait memory (response 1 cycle after accept), inst_valid rises 1 cycle after the response.
  - Sustained throughput is 1 instruction per cycle when DEPTH ≥ 2 and inst_ready = 1.
- Arithmetic: all PC adds are 32-bit modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is permitted.
- Reset mid-operation clears everything immediately. Responses to pre-reset requests are the memory's responsibility and must not arrive after reset.

Test Plan:
- Reset release, memory with ready = 1 and 1-cycle response returning addr^32'hA5A5_0000:
  - imem_req_valid first high in cycle 2 with addr 0.
  - inst_valid in cycle 4 with inst_pc = 0 and inst_pcplus4 = 4.
  - Then one instruction per cycle at PC 4, 8, 12.
- Stall with inst_ready = 0 for 10 cycles:
  - Exactly 2 requests issued, then imem_req_valid = 0.
  - inst and inst_pc hold at PC 0.
  - On release, PCs 0, 4, 8 are delivered in order with no gaps or duplicates.
- Memory latency 3 cycles, redirect to 32'h0000_0100 with 2 requests outstanding:
  - State is FLUSH for 2 responses, both discarded.
  - Next delivered inst_pc = 0x100.
- Redirect in the same cycle as imem_rsp_valid and a pop at PC 8:
  - PC 8 is consumed; the response word is dropped.
  - The next instruction delivered is from redirect_pc.
- Misaligned redirect_pc = 32'h0000_0206: next imem_req_addr = 32'h0000_0204.
- Assert reset_n low mid-stream with 1 outstanding:
  - All outputs return to reset values asynchronously, before the next clk edge.
  - After release, fetch restarts at RESET_PC.
